// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for the single register-file write port.
//
// Two writeback sources share the port. src0 is the ALU result and src1 is the
// memory load return. Each source has its own DEPTH-entry FIFO with a valid/ready
// handshake. Every accepted entry is stamped with an arrival sequence number.
// Entries accepted on the same edge get the same stamp. The scheduler retires the
// oldest head each cycle, so writes leave in program order. Equal-stamp heads are
// resolved by a round-robin bit.
//
// The optional macro R0_ZERO_EN makes register 0 hardwired zero. A head with
// dst == 0 still pops and still uses its grant cycle, but it never raises
// regwrite, and pending[0] stays low.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   srcN_valid / srcN_ready     enqueue handshake for source N (ready = FIFO not full)
//   srcN_dst / srcN_data        destination register and write data
//   regwrite/regdst/writedata   register-file write port, driven from the granted head
//   pending                     bit r set while any queued entry targets register r
module regfile_wb_scheduler #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned SEQ_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        src0_valid,
    output logic        src0_ready,
    input  logic [3:0]  src0_dst,
    input  logic [15:0] src0_data,
    input  logic        src1_valid,
    output logic        src1_ready,
    input  logic [3:0]  src1_dst,
    input  logic [15:0] src1_data,
    output logic        regwrite,
    output logic [3:0]  regdst,
    output logic [15:0] writedata,
    output logic [15:0] pending
);

    localparam int unsigned NSRC   = 2;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREG   = 16;
    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [REG_W-1:0]  dst;
        logic [DATA_W-1:0] data;
        logic [SEQ_W-1:0]  seq;
    } entry_t;

    // Architectural state
    entry_t           mem_q  [NSRC][DEPTH];
    entry_t           mem_d  [NSRC][DEPTH];
    logic [PTR_W-1:0] wptr_q [NSRC];
    logic [PTR_W-1:0] wptr_d [NSRC];
    logic [PTR_W-1:0] rptr_q [NSRC];
    logic [PTR_W-1:0] rptr_d [NSRC];
    logic [CNT_W-1:0] cnt_q  [NSRC];
    logic [CNT_W-1:0] cnt_d  [NSRC];
    logic [SEQ_W-1:0] seq_q;
    logic [SEQ_W-1:0] seq_d;
    logic             rr_q;
    logic             rr_d;

    // Per-source views of ports and FIFO heads
    logic             in_valid   [NSRC];
    entry_t           in_entry   [NSRC];
    logic             ready      [NSRC];
    logic             accept     [NSRC];
    logic             head_valid [NSRC];
    entry_t           head       [NSRC];
    logic             pop        [NSRC];

    // Grant
    logic             gnt_valid;
    logic             gnt_sel;
    logic             gnt_tie;
    logic [SEQ_W-1:0] age_diff;
    entry_t           gnt_entry;
    logic             wr_en;
    logic [NREG-1:0]  pend_c;

    // Port gathering, handshake and head extraction
    always_comb begin
        in_valid[0] = src0_valid;
        in_valid[1] = src1_valid;
        in_entry[0] = '{dst: src0_dst, data: src0_data, seq: seq_q};
        in_entry[1] = '{dst: src1_dst, data: src1_data, seq: seq_q};
        for (int unsigned s = 0; s < NSRC; s++) begin
            // Ready depends only on the registered count, so a pop cannot free a slot in the same cycle.
            ready[s]      = (cnt_q[s] != CNT_W'(DEPTH));
            accept[s]     = in_valid[s] && ready[s];
            head_valid[s] = (cnt_q[s] != '0);
            head[s]       = mem_q[s][rptr_q[s]];
        end
    end

    assign src0_ready = ready[0];
    assign src1_ready = ready[1];

    // Oldest-first arbitration; the modulo difference tolerates stamp wrap-around.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_sel   = 1'b0;
        gnt_tie   = 1'b0;
        age_diff  = head[0].seq - head[1].seq;
        if (head_valid[0] && head_valid[1]) begin
            gnt_valid = 1'b1;
            if (head[0].seq == head[1].seq) begin
                gnt_tie = 1'b1;
                gnt_sel = rr_q;
            end else begin
                // MSB set means src0 is older.
                gnt_sel = ~age_diff[SEQ_W-1];
            end
        end else if (head_valid[0]) begin
            gnt_valid = 1'b1;
            gnt_sel   = 1'b0;
        end else if (head_valid[1]) begin
            gnt_valid = 1'b1;
            gnt_sel   = 1'b1;
        end
        pop[0]    = gnt_valid && !gnt_sel;
        pop[1]    = gnt_valid && gnt_sel;
        gnt_entry = head[gnt_sel];
    end

    // Write port: the granted head is presented now and pops on the edge that writes it.
    always_comb begin
`ifdef R0_ZERO_EN
        wr_en = gnt_valid && (gnt_entry.dst != '0);
`else
        wr_en = gnt_valid;
`endif
        regwrite  = wr_en;
        regdst    = wr_en ? gnt_entry.dst  : '0;
        writedata = wr_en ? gnt_entry.data : '0;
    end

    // FIFO, sequence stamp and round-robin next state
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        seq_d  = seq_q;
        rr_d   = rr_q;
        for (int unsigned s = 0; s < NSRC; s++) begin
            if (accept[s]) begin
                mem_d[s][wptr_q[s]] = in_entry[s];
                wptr_d[s]           = wptr_q[s] + PTR_W'(1);
            end
            if (pop[s]) begin
                rptr_d[s] = rptr_q[s] + PTR_W'(1);
            end
            cnt_d[s] = cnt_q[s] + CNT_W'(accept[s]) - CNT_W'(pop[s]);
        end
        // One stamp per accepting edge; a same-edge pair shares it.
        if (accept[0] || accept[1]) begin
            seq_d = seq_q + SEQ_W'(1);
        end
        if (gnt_tie) begin
            rr_d = ~rr_q;
        end
    end

    // Pending bitmap over every occupied entry of both FIFOs
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx    = '0;
        pend_c = '0;
        for (int unsigned s = 0; s < NSRC; s++) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                idx = rptr_q[s] + PTR_W'(k);
                if (CNT_W'(k) < cnt_q[s]) begin
                    pend_c[mem_q[s][idx].dst] = 1'b1;
                end
            end
        end
`ifdef R0_ZERO_EN
        pend_c[0] = 1'b0;
`endif
        pending = pend_c;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q  <= '{default: '0};
            wptr_q <= '{default: '0};
            rptr_q <= '{default: '0};
            cnt_q  <= '{default: '0};
            seq_q  <= '0;
            rr_q   <= 1'b0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            seq_q  <= seq_d;
            rr_q   <= rr_d;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler.
// Producer queues feed the two sources under the valid/ready protocol.
// A scoreboard, in arrival order, predicts every register-file write.
// A table covers single-edge transactions, and hand-written sequences cover
// reset, ordering, backpressure, R0 handling and tie fairness.
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        src0_valid = 1'b0;
    logic        src0_ready;
    logic [3:0]  src0_dst = '0;
    logic [15:0] src0_data = '0;
    logic        src1_valid = 1'b0;
    logic        src1_ready;
    logic [3:0]  src1_dst = '0;
    logic [15:0] src1_data = '0;
    logic        regwrite;
    logic [3:0]  regdst;
    logic [15:0] writedata;
    logic [15:0] pending;

    regfile_wb_scheduler dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .src0_valid (src0_valid),
        .src0_ready (src0_ready),
        .src0_dst   (src0_dst),
        .src0_data  (src0_data),
        .src1_valid (src1_valid),
        .src1_ready (src1_ready),
        .src1_dst   (src1_dst),
        .src1_data  (src1_data),
        .regwrite   (regwrite),
        .regdst     (regdst),
        .writedata  (writedata),
        .pending    (pending)
    );

    always #5 clk = ~clk;

`ifdef R0_ZERO_EN
    localparam logic [15:0] P0   = 16'h0000;
    localparam logic        R0WR = 1'b0;
`else
    localparam logic [15:0] P0   = 16'h0001;
    localparam logic        R0WR = 1'b1;
`endif

    typedef struct packed {
        logic [3:0]  dst;
        logic [15:0] data;
    } item_t;

    typedef struct {
        logic        v0;
        logic [3:0]  d0;
        logic [15:0] x0;
        logic        v1;
        logic [3:0]  d1;
        logic [15:0] x1;
        logic [15:0] exp_pend;
    } vec_t;

    item_t       pq0[$];
    item_t       pq1[$];
    item_t       sb[$];
    item_t       exp_item;
    logic [15:0] rf [16];
    int          checks = 0;
    int          errors = 0;
    logic        acc0 = 1'b0;
    logic        acc1 = 1'b0;
    logic        tb_rr = 1'b0;
    logic        tie_mode = 1'b0;
    int          cyc = 0;
    int          nwr0 = 0;
    int          nwr1 = 0;
    int          first_wr = -1;
    int          last_wr = -1;
    int          max_imb = 0;
    int          imb;
    vec_t        vecs [6];

    function automatic void sb_push(input item_t it);
`ifdef R0_ZERO_EN
        if (it.dst == 4'd0) return;
`endif
        sb.push_back(it);
    endfunction

    // Write monitor and scoreboard feed, sampled on the falling edge
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            sb.delete();
            tb_rr = 1'b0;
            acc0  = 1'b0;
            acc1  = 1'b0;
        end else begin
            checks++;
            if (regwrite) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL spurious_write: got dst=%0d data=%h, expected no write", regdst, writedata);
                end else begin
                    exp_item = sb.pop_front();
                    if (regdst !== exp_item.dst || writedata !== exp_item.data) begin
                        errors++;
                        $display("FAIL write_order: got dst=%0d data=%h, expected dst=%0d data=%h",
                                 regdst, writedata, exp_item.dst, exp_item.data);
                    end
                end
                rf[regdst] = writedata;
                if (tie_mode) begin
                    if (regdst[3]) nwr1++; else nwr0++;
                    if (first_wr < 0) first_wr = cyc;
                    last_wr = cyc;
                    imb = nwr0 - nwr1;
                    if (imb < 0) imb = -imb;
                    if (imb > max_imb) max_imb = imb;
                end
            end else if (regdst !== 4'd0 || writedata !== 16'd0) begin
                errors++;
                $display("FAIL idle_zero: got dst=%0d data=%h, expected 0/0", regdst, writedata);
            end
            acc0 = src0_valid && src0_ready;
            acc1 = src1_valid && src1_ready;
            // Same-edge pairs share a stamp and retire in round-robin order.
            if (acc0 && acc1) begin
                if (tb_rr) begin
                    sb_push(pq1[0]);
                    sb_push(pq0[0]);
                end else begin
                    sb_push(pq0[0]);
                    sb_push(pq1[0]);
                end
                tb_rr = ~tb_rr;
            end else if (acc0) begin
                sb_push(pq0[0]);
            end else if (acc1) begin
                sb_push(pq1[0]);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply();
        src0_valid = (pq0.size() != 0);
        src0_dst   = src0_valid ? pq0[0].dst  : 4'd0;
        src0_data  = src0_valid ? pq0[0].data : 16'd0;
        src1_valid = (pq1.size() != 0);
        src1_dst   = src1_valid ? pq1[0].dst  : 4'd0;
        src1_data  = src1_valid ? pq1[0].data : 16'd0;
    endtask

    // Advance to just after the next rising edge and retire accepted producer items.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (acc0) void'(pq0.pop_front());
        if (acc1) void'(pq1.pop_front());
        apply();
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((pq0.size() != 0 || pq1.size() != 0 || sb.size() != 0 || pending != 16'd0) && n < 200) begin
            cycle();
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL %s_drain: got pending=%h sb=%0d after %0d cycles, expected all drained",
                     name, pending, sb.size(), n);
        end
        repeat (2) cycle();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        pq0.delete();
        pq1.delete();
        apply();
        @(negedge clk);
        chk("rst_regwrite", 32'(regwrite), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_ready", {30'd0, src1_ready, src0_ready}, 32'd3);
        cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 4'd3,  16'h1234, 1'b0, 4'd0,  16'h0000, 16'h0008};
        vecs[1] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd5,  16'h5555, 16'h0020};
        vecs[2] = '{1'b1, 4'd1,  16'h0101, 1'b1, 4'd2,  16'h0202, 16'h0006};
        vecs[3] = '{1'b1, 4'd7,  16'h7070, 1'b1, 4'd7,  16'h0707, 16'h0080};
        vecs[4] = '{1'b1, 4'd0,  16'hF00D, 1'b0, 4'd0,  16'h0000, P0};
        vecs[5] = '{1'b1, 4'd15, 16'hFFFF, 1'b1, 4'd0,  16'hCAFE, 16'h8000 | P0};

        // Reset held with both valids high
        pq0.push_back('{4'd2, 16'hAAAA});
        pq1.push_back('{4'd4, 16'hBBBB});
        apply();
        repeat (3) cycle();
        @(negedge clk);
        chk("rst_hold_regwrite", 32'(regwrite), 32'd0);
        chk("rst_hold_pending", 32'(pending), 32'd0);
        chk("rst_hold_ready", {30'd0, src1_ready, src0_ready}, 32'd3);
        cycle();
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_pending", 32'(pending), 32'd0);
        chk("post_rst_regwrite", 32'(regwrite), 32'd0);
        cycle();
        @(negedge clk);
        chk("first_accept_pending", 32'(pending), 32'h0014);
        chk("first_accept_dst", 32'(regdst), 32'd2);
        wait_drain("reset");

        // Single write latency and pending clear
        pq0.push_back('{4'd3, 16'hBEEF});
        apply();
        cycle();
        @(negedge clk);
        chk("single_pending", 32'(pending), 32'h0008);
        chk("single_regwrite", 32'(regwrite), 32'd1);
        chk("single_regdst", 32'(regdst), 32'd3);
        chk("single_data", 32'(writedata), 32'hBEEF);
        cycle();
        @(negedge clk);
        chk("single_pending_clr", 32'(pending), 32'd0);
        chk("single_idle", 32'(regwrite), 32'd0);
        wait_drain("single");

        // Cross-source ordering to the same register
        pq1.push_back('{4'd5, 16'h1111});
        apply();
        cycle();
        pq0.push_back('{4'd5, 16'h2222});
        apply();
        @(negedge clk);
        chk("order_first", 32'(writedata), 32'h1111);
        cycle();
        @(negedge clk);
        chk("order_second", 32'(writedata), 32'h2222);
        wait_drain("order");
        chk("order_r5", 32'(rf[5]), 32'h2222);

        // Table of single-edge transactions
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("vec%0d_ready", i), {30'd0, src1_ready, src0_ready}, 32'd3);
            if (vecs[i].v0) pq0.push_back('{vecs[i].d0, vecs[i].x0});
            if (vecs[i].v1) pq1.push_back('{vecs[i].d1, vecs[i].x1});
            apply();
            cycle();
            @(negedge clk);
            chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(vecs[i].exp_pend));
            wait_drain($sformatf("vec%0d", i));
        end

        // Register 0 handling
        pq0.push_back('{4'd0, 16'h5A5A});
        apply();
        cycle();
        @(negedge clk);
        chk("r0_regwrite", 32'(regwrite), 32'(R0WR));
        chk("r0_regdst", 32'(regdst), 32'd0);
        chk("r0_pending", 32'(pending), 32'(P0));
        cycle();
        @(negedge clk);
        chk("r0_popped", 32'(pending), 32'd0);
        wait_drain("r0");

        // Reset mid-operation discards queued writes
        for (int i = 0; i < 3; i++) begin
            pq0.push_back('{4'(9 + i), 16'h9000 + 16'(i)});
            pq1.push_back('{4'(12 + i), 16'hE000 + 16'(i)});
        end
        apply();
        cycle();
        cycle();
        reset_dut();
        @(negedge clk);
        chk("midrst_pending", 32'(pending), 32'd0);
        chk("midrst_regwrite", 32'(regwrite), 32'd0);
        cycle();

        // Backpressure on src1 from a fresh reset state
        reset_dut();
        pq0.push_back('{4'd1, 16'hA000});
        pq0.push_back('{4'd2, 16'hA001});
        pq1.push_back('{4'd10, 16'hB000});
        pq1.push_back('{4'd11, 16'hB001});
        pq1.push_back('{4'd12, 16'hB002});
        apply();
        cycle();
        cycle();
        @(negedge clk);
        chk("bp_src1_full", 32'(src1_ready), 32'd0);
        chk("bp_src0_ready", 32'(src0_ready), 32'd1);
        chk("bp_oldest_first", 32'(regdst), 32'd10);
        cycle();
        @(negedge clk);
        chk("bp_src1_freed", 32'(src1_ready), 32'd1);
        chk("bp_tie_rr", 32'(regdst), 32'd11);
        wait_drain("bp");
        chk("bp_held_req", 32'(rf[12]), 32'hB002);

        // Both sources streaming: fairness, throughput, no drops
        nwr0 = 0;
        nwr1 = 0;
        first_wr = -1;
        last_wr = -1;
        max_imb = 0;
        tie_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pq0.push_back('{4'(1 + (i % 7)), 16'hC000 + 16'(i)});
            pq1.push_back('{4'(8 + i), 16'hD000 + 16'(i)});
        end
        apply();
        wait_drain("tie");
        tie_mode = 1'b0;
        chk("tie_src0_writes", 32'(nwr0), 32'd8);
        chk("tie_src1_writes", 32'(nwr1), 32'd8);
        chk("tie_throughput", 32'(last_wr - first_wr + 1), 32'd16);
        chk("tie_balance", 32'(max_imb <= 2), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
